fpa_issue: RTL and testbench
============================

FPA_ISSUE -- requirements
Module: fpa_issue

Interface
REQ-001 Parameter: TAG_W, 4, width of the transaction tag attached to each operand pair.
REQ-002 Parameter: DEPTH, 2, number of entries in the operand buffer; legal values are 2 and 4.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: in_valid  input  1  upstream operand pair valid.
REQ-006 Port: in_ready  output  1  buffer can accept a pair this cycle.
REQ-007 Port: in_a  input  32  IEEE-754 single operand A.
REQ-008 Port: in_b  input  32  IEEE-754 single operand B.
REQ-009 Port: in_sub  input  1  1 = compute A-B, 0 = A+B.
REQ-010 Port: out_valid  output  1  head entry presented to the adder.
REQ-011 Port: out_ready  input  1  adder accepts the head entry.
REQ-012 Port: out_a  output  32  operand A to the adder.
REQ-013 Port: out_b  output  32  operand B to the adder, with sign already adjusted for subtract.
REQ-014 Port: out_special  output  1  1 = the adder result must be replaced by out_result.
REQ-015 Port: out_result  output  32  special-case result; zero when out_special=0.
REQ-016 Port: out_tag  output  TAG_W  tag of the head entry.
REQ-017 Port: count  output  3  current buffer occupancy, 0..DEPTH.

Function
REQ-018 Accept (push) occurs when in_valid=1 and in_ready=1.
REQ-019 Issue (pop) occurs when out_valid=1 and out_ready=1.
REQ-020 in_ready SHALL equal (count<DEPTH) and depend on registered state only, never on out_ready.
- Consequence: when full, no push occurs even if a pop happens in the same cycle.
REQ-021 Simultaneous push and pop with 0<count<DEPTH: count unchanged; new entry is written behind the head.
REQ-022 Latency from accept to out_valid SHALL be 1 cycle; there is no combinational bypass from input to output.
REQ-023 out_valid SHALL equal (count!=0); all out_* SHALL be driven from the head entry's registered fields.
REQ-024 Head outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Buffer pointers SHALL wrap modulo DEPTH.
REQ-026 Sign adjustment at accept: b' = {in_b[31]^in_sub, in_b[30:0]}; out_a = in_a and out_b = b'.
REQ-027 Classification of each operand x: exp=8'hFF with mant!=0 is NaN; exp=8'hFF with mant=0 is Inf; exp=0 is Zero (denormals are flushed to zero, sign kept).
REQ-028 Special-case rules, evaluated at accept using in_a and b', in priority order:
- (a) either operand NaN -> 32'h7FC00000;
- (b) both Inf with opposite signs -> 32'h7FC00000;
- (c) either operand Inf -> that Inf (A wins if both are Inf);
- (d) both Zero -> sign = signA & signB', result {sign,31'b0};
- (e) exactly one Zero -> the other operand unchanged.
- Any rule hit sets special=1; otherwise special=0 and result=0.
REQ-029 Tag counter: starts at 0; each accepted pair takes the current value; counter increments by 1 per accept and wraps from all-ones to 0.
REQ-030 Contents of empty buffer entries are don't-care, but out_a, out_b, out_result and out_tag SHALL read 0 when count=0.

Reset
REQ-031 While rst_n=0: count=0, in_ready=0, out_valid=0, out_special=0, out_a=out_b=out_result=0, out_tag=0, tag counter=0.
REQ-032 Assertion of rst_n mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-033 in_ready SHALL rise on the first clk edge after rst_n deasserts; no accept occurs on that edge.

Verification
REQ-034 Basic add: in_a=3F800000, in_b=40000000, in_sub=0, out_ready=1 -> next cycle out_valid=1, out_a=3F800000, out_b=40000000, out_special=0, out_tag=0.
REQ-035 Subtract: in_a=40400000, in_b=3F800000, in_sub=1 -> out_b=BF800000, out_special=0.
REQ-036 Special cases:
- in_a=7F800000, in_b=7F800000, in_sub=1 -> out_special=1, out_result=7FC00000;
- in_a=80000000, in_b=00000000, in_sub=1 -> out_special=1, out_result=80000000.
REQ-037 Backpressure with DEPTH=2: out_ready=0, present 3 pairs back-to-back -> count=2, in_ready=0, third pair held; raise out_ready -> pairs issue in order with tags 0,1,2 and outputs stable while stalled.
REQ-038 Tag wrap: 17 accepts -> 17th pair carries tag 0.
REQ-039 Reset mid-operation: rst_n pulled low with count=2 -> count=0 and out_valid=0 without a clock edge; after release the next accepted pair carries tag 0.

Source files
------------

// File: rtl/fpa_issue.sv
// Operand buffer in front of a single-precision adder: accepts A/B pairs, pre-adjusts
// the B sign for subtract, tags each pair and flags NaN/Inf/Zero special-case results.
module fpa_issue #(
   parameter int TAG_W = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_a,
   output logic [31:0]      out_b,
   output logic             out_special,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic [2:0]       count
);

   localparam int         PTR_W   = (DEPTH > 2) ? 2 : 1;
   localparam logic [2:0] DEPTH_C = 3'(DEPTH);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [2:0]       occ;
   logic [TAG_W-1:0] tag_cnt;
   logic             rdy_en;
   logic             push;
   logic             pop;

   logic [31:0]      mem_a   [DEPTH];
   logic [31:0]      mem_b   [DEPTH];
   logic [31:0]      mem_res [DEPTH];
   logic             mem_spc [DEPTH];
   logic [TAG_W-1:0] mem_tag [DEPTH];

   logic [31:0] b_adj;
   logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic        spc;
   logic [31:0] res;

   // rdy_en keeps in_ready low until the first edge after reset release
   assign in_ready  = rdy_en & (occ < DEPTH_C);
   assign out_valid = (occ != 3'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign count     = occ;

   assign b_adj  = {in_b[31] ^ in_sub, in_b[30:0]};
   assign nan_a  = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'd0);
   assign nan_b  = (b_adj[30:23] == 8'hFF) && (b_adj[22:0] != 23'd0);
   assign inf_a  = (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'd0);
   assign inf_b  = (b_adj[30:23] == 8'hFF) && (b_adj[22:0] == 23'd0);
   assign zero_a = (in_a[30:23] == 8'h00);
   assign zero_b = (b_adj[30:23] == 8'h00);

   always_comb begin
      spc = 1'b1;
      res = 32'd0;
      if (nan_a || nan_b) begin
         res = 32'h7FC0_0000;
      end else if (inf_a && inf_b && (in_a[31] != b_adj[31])) begin
         res = 32'h7FC0_0000;
      end else if (inf_a) begin
         res = in_a;
      end else if (inf_b) begin
         res = b_adj;
      end else if (zero_a && zero_b) begin
         res = {in_a[31] & b_adj[31], 31'd0};
      end else if (zero_a) begin
         res = b_adj;
      end else if (zero_b) begin
         res = in_a;
      end else begin
         spc = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         occ     <= 3'd0;
         tag_cnt <= '0;
         rdy_en  <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (push) begin
            wr_ptr  <= wr_ptr + PTR_W'(1);
            tag_cnt <= tag_cnt + TAG_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   occ <= occ + 3'd1;
            2'b01:   occ <= occ - 3'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Entry payload needs no reset: it is only visible while occupancy covers it
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]   <= in_a;
         mem_b[wr_ptr]   <= b_adj;
         mem_res[wr_ptr] <= res;
         mem_spc[wr_ptr] <= spc;
         mem_tag[wr_ptr] <= tag_cnt;
      end
   end

   assign out_a       = out_valid ? mem_a[rd_ptr]   : 32'd0;
   assign out_b       = out_valid ? mem_b[rd_ptr]   : 32'd0;
   assign out_result  = out_valid ? mem_res[rd_ptr] : 32'd0;
   assign out_special = out_valid ? mem_spc[rd_ptr] : 1'b0;
   assign out_tag     = out_valid ? mem_tag[rd_ptr] : '0;

endmodule

// File: tb/tb_fpa_issue.sv
// Directed self-checking bench for fpa_issue (DEPTH=2, TAG_W=4).
module tb_fpa_issue;

   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_a = 32'd0;
   logic [31:0]      in_b = 32'd0;
   logic             in_sub = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_a;
   logic [31:0]      out_b;
   logic             out_special;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;
   logic [2:0]       count;

   int n_cmp = 0;
   int n_err = 0;
   logic [TAG_W-1:0] exp_tag = '0;

   localparam logic [31:0] SA   [8] = '{32'h7F800000, 32'h80000000, 32'h7F800001, 32'h3F800000,
                                        32'h00000000, 32'h00000001, 32'h7F800000, 32'h40400000};
   localparam logic [31:0] SB   [8] = '{32'h7F800000, 32'h00000000, 32'h3F800000, 32'hFF800000,
                                        32'h40000000, 32'h40400000, 32'h7F800000, 32'h3F800000};
   localparam logic        SSUB [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic        SSPC [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam logic [31:0] SRES [8] = '{32'h7FC00000, 32'h80000000, 32'h7FC00000, 32'hFF800000,
                                        32'hC0000000, 32'h40400000, 32'h7F800000, 32'h00000000};

   fpa_issue #(.TAG_W(TAG_W), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_special(out_special),
      .out_result(out_result), .out_tag(out_tag), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_one(input logic [31:0] a, input logic [31:0] b, input logic sub);
      in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      exp_tag = '0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (count !== 3'd0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_special !== 1'b0) begin
         n_err++; $display("FAIL reset_ctrl: count=%0d in_ready=%b out_valid=%b special=%b want 0/0/0/0",
                           count, in_ready, out_valid, out_special); end
      n_cmp++; if (out_a !== 32'd0 || out_b !== 32'd0 || out_result !== 32'd0 || out_tag !== 4'd0) begin
         n_err++; $display("FAIL reset_data: a=%h b=%h res=%h tag=%0d want all 0",
                           out_a, out_b, out_result, out_tag); end
      @(posedge clk); #3 rst_n = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL release_ready: got %b want 0 before first edge", in_ready); end
      in_a = 32'h3F800000; in_b = 32'h3F800000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++; if (in_ready !== 1'b1 || count !== 3'd0) begin
         n_err++; $display("FAIL first_edge: in_ready=%b count=%0d want 1/0", in_ready, count); end
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      push_one(32'h3F800000, 32'h40000000, 1'b0);
      n_cmp++; if (out_valid !== 1'b1 || count !== 3'd1) begin
         n_err++; $display("FAIL add_valid: out_valid=%b count=%0d want 1/1", out_valid, count); end
      n_cmp++; if (out_a !== 32'h3F800000 || out_b !== 32'h40000000) begin
         n_err++; $display("FAIL add_ops: a=%h b=%h want 3f800000/40000000", out_a, out_b); end
      n_cmp++; if (out_special !== 1'b0 || out_result !== 32'd0 || out_tag !== exp_tag) begin
         n_err++; $display("FAIL add_flags: special=%b res=%h tag=%0d want 0/0/%0d",
                           out_special, out_result, out_tag, exp_tag); end
      exp_tag++;
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0 || out_a !== 32'd0 || out_tag !== 4'd0) begin
         n_err++; $display("FAIL add_empty: valid=%b count=%0d a=%h tag=%0d want 0/0/0/0",
                           out_valid, count, out_a, out_tag); end
   endtask

   task automatic test_sub();
      out_ready = 1'b1;
      push_one(32'h40400000, 32'h3F800000, 1'b1);
      n_cmp++; if (out_a !== 32'h40400000 || out_b !== 32'hBF800000 || out_special !== 1'b0) begin
         n_err++; $display("FAIL sub_ops: a=%h b=%h special=%b want 40400000/bf800000/0",
                           out_a, out_b, out_special); end
      n_cmp++; if (out_tag !== exp_tag) begin
         n_err++; $display("FAIL sub_tag: got %0d want %0d", out_tag, exp_tag); end
      exp_tag++;
      @(posedge clk); #1;
   endtask

   task automatic test_special();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push_one(SA[i], SB[i], SSUB[i]);
         n_cmp++; if (out_special !== SSPC[i] || out_result !== SRES[i]) begin
            n_err++; $display("FAIL special_%0d: special=%b res=%h want %b/%h",
                              i, out_special, out_result, SSPC[i], SRES[i]); end
         n_cmp++; if (out_b !== {SB[i][31] ^ SSUB[i], SB[i][30:0]} || out_tag !== exp_tag) begin
            n_err++; $display("FAIL special_%0d_b: b=%h tag=%0d want %h/%0d", i, out_b, out_tag,
                              {SB[i][31] ^ SSUB[i], SB[i][30:0]}, exp_tag); end
         exp_tag++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b0;
      in_b = 32'h40000000; in_sub = 1'b0;
      in_a = 32'h3F800000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_a = 32'h40000000;
      @(posedge clk); #1;
      in_a = 32'h40400000;
      n_cmp++; if (count !== 3'd2 || in_ready !== 1'b0) begin
         n_err++; $display("FAIL bp_full: count=%0d in_ready=%b want 2/0", count, in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (count !== 3'd2 || out_a !== 32'h3F800000 || out_tag !== 4'd0) begin
         n_err++; $display("FAIL bp_stall: count=%0d a=%h tag=%0d want 2/3f800000/0",
                           count, out_a, out_tag); end
      @(posedge clk); #1;
      n_cmp++; if (out_a !== 32'h3F800000 || out_b !== 32'h40000000 || out_valid !== 1'b1) begin
         n_err++; $display("FAIL bp_hold: a=%h b=%h valid=%b want 3f800000/40000000/1",
                           out_a, out_b, out_valid); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (count !== 3'd1 || out_a !== 32'h40000000 || out_tag !== 4'd1 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_pop1: count=%0d a=%h tag=%0d rdy=%b want 1/40000000/1/1",
                           count, out_a, out_tag, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++; if (count !== 3'd1 || out_a !== 32'h40400000 || out_tag !== 4'd2) begin
         n_err++; $display("FAIL bp_pop2: count=%0d a=%h tag=%0d want 1/40400000/2",
                           count, out_a, out_tag); end
      @(posedge clk); #1;
      n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL bp_drain: count=%0d valid=%b want 0/0", count, out_valid); end
   endtask

   task automatic test_tag_wrap();
      do_reset();
      out_ready = 1'b1;
      in_a = 32'h3F800000; in_b = 32'h3F800000; in_sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (out_tag !== exp_tag || count !== 3'd1) begin
            n_err++; $display("FAIL tag_%0d: tag=%0d count=%0d want %0d/1", i, out_tag, count, exp_tag); end
         exp_tag++;
      end
      in_valid = 1'b0;
      n_cmp++; if (out_tag !== 4'd0) begin
         n_err++; $display("FAIL tag_wrap17: got %0d want 0", out_tag); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      push_one(32'h40000000, 32'h40000000, 1'b0);
      push_one(32'h40400000, 32'h40000000, 1'b0);
      n_cmp++; if (count !== 3'd2) begin
         n_err++; $display("FAIL mid_fill: count=%0d want 2", count); end
      rst_n = 1'b0;
      #2;
      n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_a !== 32'd0) begin
         n_err++; $display("FAIL mid_async: count=%0d valid=%b rdy=%b a=%h want 0/0/0/0",
                           count, out_valid, in_ready, out_a); end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      push_one(32'h3F800000, 32'h40000000, 1'b0);
      n_cmp++; if (out_tag !== 4'd0 || count !== 3'd1 || out_a !== 32'h3F800000) begin
         n_err++; $display("FAIL mid_retag: tag=%0d count=%0d a=%h want 0/1/3f800000",
                           out_tag, count, out_a); end
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_special();
      test_back_to_back();
      test_tag_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
